blink_ctrl: RTL
===============

Name: blink_ctrl

Overview:
Sequences the LED bank from debounced single-cycle button pulses. It keeps a saturating blink-rate index and a 3-state display-mode FSM, and runs a half-period timer derived from the rate index. On each timer expiry it updates the LED pattern. It sits between the per-button debounce instances and the board LED pins.

Parameters:
BASE_CYC, 15625000, half-period in CLK cycles at the fastest rate (0.125 s at 125 MHz).
NUM_RATES, 4, number of rate steps. Half-period(idx) = BASE_CYC << (NUM_RATES-1-idx), so idx 0 is slowest.
NUM_LED, 4, LED count, >= 2.

Ports:
CLK  in  1  system clock, 125 MHz.
RST  in  1  synchronous, active-high reset.
BTN_UP  in  1  debounced 1-cycle pulse; faster rate.
BTN_DN  in  1  debounced 1-cycle pulse; slower rate.
BTN_MODE  in  1  debounced 1-cycle pulse; advance display mode.
LED  out  NUM_LED  LED drive, registered.
RATE_IDX  out  $clog2(NUM_RATES)  current rate index, registered.
MODE  out  2  current mode (mode_t encoding), registered.
TICK  out  1  registered 1-cycle pulse on each half-period expiry.

Behaviour:
- One clock (CLK). Reset is synchronous, active-high (RST). All state updates on posedge CLK.
- Reset values: RATE_IDX=0, MODE=MODE_BLINK, LED=0, TICK=0, timer cnt=0.
- Rate index:
  - BTN_UP alone increments RATE_IDX, saturating at NUM_RATES-1.
  - BTN_DN alone decrements RATE_IDX, saturating at 0.
  - BTN_UP and BTN_DN in the same cycle: no change.
- Rate-change restart:
  - Any actual RATE_IDX change loads cnt=0 on the same edge. LED is held and TICK=0 that cycle.
  - A saturated press (no change) does not disturb cnt.
- Timer:
  - cnt counts 0..HALF-1, where HALF is computed from the registered RATE_IDX.
  - On the edge where cnt==HALF-1 (and no restart): cnt<=0, TICK<=1, and LED<=next pattern in the same edge. Otherwise TICK<=0.
  - First expiry occurs HALF cycles after reset release or restart.
  - cnt width = $clog2(BASE_CYC<<(NUM_RATES-1)). The half-period computation must not overflow at idx 0.
- Mode FSM: MODE_BLINK -> MODE_SHIFT -> MODE_OFF -> MODE_BLINK, advanced by BTN_MODE.
  - A mode change restarts cnt=0 and loads the entry pattern:
    - BLINK entry: LED=0.
    - SHIFT entry: LED=1 (bit 0 set).
    - OFF entry: LED=0.
- Per-tick LED update:
  - BLINK: LED <= ~LED (all bits toggle together).
  - SHIFT: rotate left by 1. Bit NUM_LED-1 wraps to bit 0, so the pattern stays one-hot.
  - OFF: cnt held at 0, TICK never asserts, LED stays 0. Rate buttons still update RATE_IDX.
- Simultaneous events, priority RST > mode change > rate change > expiry:
  - BTN_MODE together with a rate change: both take effect; one restart; entry pattern loaded.
  - Any restart coinciding with cnt==HALF-1: the restart wins and no TICK is produced.
- Reset mid-operation returns everything to reset values on the next edge, regardless of mode or cnt.
- Illegal MODE encoding (2'd3) goes to MODE_BLINK with LED=0 on the next edge.

Decomposition:
- Package blink_pkg:
  - typedef enum logic [1:0] mode_t {MODE_BLINK=0, MODE_SHIFT=1, MODE_OFF=2}.
  - localparam helpers for RATE_W and CNT_W computation.
- Sub-module blink_timer: inputs CLK, RST, restart, enable, half_cyc; output expire.
  - Holds cnt only; restart takes precedence over expiry.
- blink_ctrl holds the rate register, mode FSM and LED pattern register.

Test Plan:
Benches use BASE_CYC=4, NUM_RATES=4, NUM_LED=4, giving half-periods 32/16/8/4.
1. Release RST at cycle 0, no buttons -> LED=0000 until the first TICK at cycle 32, then LED=1111; toggles every 32 cycles; RATE_IDX=0, MODE=0 throughout.
2. Five BTN_UP pulses spaced 50 cycles apart -> RATE_IDX 1,2,3,3,3; TICK period becomes 4 cycles; the 4th and 5th pulses cause no counter restart (TICK spacing stays 4 across them).
3. BTN_MODE once at RATE_IDX=3 -> MODE=1, LED=0001, then 0010, 0100, 1000, 0001 on successive TICKs 4 cycles apart.
4. BTN_MODE again -> MODE=2, LED=0000 and no TICK for 200 cycles; BTN_DN pulse -> RATE_IDX 2, LED still 0000; BTN_MODE -> MODE=0, LED=0000, first TICK 8 cycles later.
5. BTN_UP and BTN_DN in the same cycle at RATE_IDX=1 -> RATE_IDX stays 1 and TICK cadence is undisturbed. BTN_UP in the same cycle cnt==HALF-1 -> no TICK that cycle, next TICK HALF(new) cycles later.
6. Assert RST mid-SHIFT with LED=0100 and cnt nonzero -> next edge LED=0000, MODE=0, RATE_IDX=0, TICK=0; first TICK 32 cycles after release.

Source files
------------

// File: rtl/blink_pkg.sv
// ----------------------------------------------------------------------------
// blink_pkg
// Shared types and width helpers for the LED blink controller.
//   mode_t       : display-mode encoding (BLINK / SHIFT / OFF; 2'd3 is illegal)
//   calc_rate_w  : width of the rate index for a given number of rate steps
//   calc_cnt_w   : width of the half-period counter (slowest rate, no overflow)
// ----------------------------------------------------------------------------
package blink_pkg;

    typedef enum logic [1:0] {
        MODE_BLINK = 2'd0,
        MODE_SHIFT = 2'd1,
        MODE_OFF   = 2'd2
    } mode_t;

    function automatic int calc_rate_w(input int num_rates);
        return (num_rates > 1) ? $clog2(num_rates) : 1;
    endfunction

    // Evaluated in 64 bits so the slowest half-period (BASE_CYC shifted by
    // NUM_RATES-1) cannot wrap before its width is taken.
    function automatic int calc_cnt_w(input longint base_cyc, input int num_rates);
        longint slowest;
        int     w;
        slowest = base_cyc << (num_rates - 1);
        w       = $clog2(slowest);
        return (w > 0) ? w : 1;
    endfunction

endpackage

// File: rtl/blink_ctrl_if.sv
// ----------------------------------------------------------------------------
// blink_ctrl_if
// Button-in / LED-out bundle of the blink controller.
//   BTN_UP, BTN_DN, BTN_MODE : debounced single-cycle button pulses
//   LED                      : registered LED drive
//   RATE_IDX                 : registered rate index (0 = slowest)
//   MODE                     : registered display mode (mode_t encoding)
//   TICK                     : registered 1-cycle pulse per half-period expiry
// master : the button side (drives pulses, observes status)
// slave  : the controller
// ----------------------------------------------------------------------------
interface blink_ctrl_if #(
    parameter int NUM_LED   = 4,
    parameter int NUM_RATES = 4
);
    import blink_pkg::*;

    localparam int RATE_W = calc_rate_w(NUM_RATES);

    logic               BTN_UP;
    logic               BTN_DN;
    logic               BTN_MODE;
    logic [NUM_LED-1:0] LED;
    logic [RATE_W-1:0]  RATE_IDX;
    logic [1:0]         MODE;
    logic               TICK;

    modport master (
        output BTN_UP, BTN_DN, BTN_MODE,
        input  LED, RATE_IDX, MODE, TICK
    );

    modport slave (
        input  BTN_UP, BTN_DN, BTN_MODE,
        output LED, RATE_IDX, MODE, TICK
    );

endinterface

// File: rtl/blink_timer.sv
// ----------------------------------------------------------------------------
// blink_timer
// Half-period counter. Counts 0..half_cyc-1 and flags the last count.
//   CLK, RST  : clock, synchronous active-high reset
//   restart   : reload count to 0 (beats expiry)
//   enable    : when low the count is held at 0 and expire never fires
//   half_cyc  : half-period length in cycles (one bit wider than the count)
//   expire    : combinational, high in the cycle whose edge ends a half-period
// ----------------------------------------------------------------------------
module blink_timer #(
    parameter int CNT_W = 5
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         restart,
    input  logic         enable,
    input  logic [CNT_W:0] half_cyc,
    output logic         expire
);
    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = ({1'b0, r_cnt} == (half_cyc - (CNT_W+1)'(1)));
    assign expire = enable && !restart && w_last;

    always_ff @(posedge CLK) begin
        if (RST || restart || !enable) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/blink_ctrl.sv
// ----------------------------------------------------------------------------
// blink_ctrl
// LED sequencer driven by debounced button pulses: saturating rate index,
// three-state display-mode FSM, and LED pattern updated on each half-period.
//   CLK  : system clock
//   RST  : synchronous active-high reset
//   bus  : blink_ctrl_if.slave (buttons in; LED, RATE_IDX, MODE, TICK out)
// ----------------------------------------------------------------------------
module blink_ctrl
    import blink_pkg::*;
#(
    parameter int BASE_CYC  = 15625000,
    parameter int NUM_RATES = 4,
    parameter int NUM_LED   = 4
) (
    input  logic        CLK,
    input  logic        RST,
    blink_ctrl_if.slave bus
);
    localparam int RATE_W = calc_rate_w(NUM_RATES);
    localparam int CNT_W  = calc_cnt_w(BASE_CYC, NUM_RATES);
    localparam int HALF_W = CNT_W + 1;

    localparam logic [RATE_W-1:0] RATE_MAX = RATE_W'(NUM_RATES - 1);
    localparam logic [HALF_W-1:0] BASE_L   = HALF_W'(BASE_CYC);

    mode_t              r_mode;
    mode_t              w_mode_nxt;
    logic               w_mode_chg;
    logic               w_enable;
    logic [RATE_W-1:0]  r_rate;
    logic [NUM_LED-1:0] r_led;
    logic [NUM_LED-1:0] w_led_nxt;
    logic               r_tick;
    logic               w_up_ok;
    logic               w_dn_ok;
    logic               w_rate_chg;
    logic               w_restart;
    logic               w_expire;
    logic [RATE_W-1:0]  w_shift;
    logic [HALF_W-1:0]  w_half;

    // Only a press that actually moves the index counts as a rate change;
    // saturated or simultaneous up+down presses leave the timer alone.
    assign w_up_ok    = bus.BTN_UP && !bus.BTN_DN && (r_rate != RATE_MAX);
    assign w_dn_ok    = bus.BTN_DN && !bus.BTN_UP && (r_rate != '0);
    assign w_rate_chg = w_up_ok || w_dn_ok;
    assign w_restart  = w_mode_chg || w_rate_chg;

    // Half-period from the registered index: idx 0 is the longest shift.
    assign w_shift = RATE_MAX - r_rate;
    assign w_half  = BASE_L << w_shift;

    blink_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .CLK      (CLK),
        .RST      (RST),
        .restart  (w_restart),
        .enable   (w_enable),
        .half_cyc (w_half),
        .expire   (w_expire)
    );

    // Mode FSM: state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_mode <= MODE_BLINK;
        end else begin
            r_mode <= w_mode_nxt;
        end
    end

    // Mode FSM: next state; an illegal encoding is forced back to BLINK and
    // flagged as a mode change so the entry pattern (0) is loaded.
    always_comb begin
        w_mode_nxt = r_mode;
        w_mode_chg = 1'b0;
        w_enable   = 1'b0;
        case (r_mode)
            MODE_BLINK: begin
                w_enable = 1'b1;
                if (bus.BTN_MODE) begin
                    w_mode_nxt = MODE_SHIFT;
                    w_mode_chg = 1'b1;
                end
            end
            MODE_SHIFT: begin
                w_enable = 1'b1;
                if (bus.BTN_MODE) begin
                    w_mode_nxt = MODE_OFF;
                    w_mode_chg = 1'b1;
                end
            end
            MODE_OFF: begin
                if (bus.BTN_MODE) begin
                    w_mode_nxt = MODE_BLINK;
                    w_mode_chg = 1'b1;
                end
            end
            default: begin
                w_mode_nxt = MODE_BLINK;
                w_mode_chg = 1'b1;
            end
        endcase
    end

    // LED pattern: entry pattern on a mode change, otherwise advance on expiry.
    always_comb begin
        w_led_nxt = r_led;
        if (w_mode_chg) begin
            w_led_nxt = (w_mode_nxt == MODE_SHIFT) ? NUM_LED'(1) : '0;
        end else if (w_expire) begin
            if (r_mode == MODE_SHIFT) begin
                w_led_nxt = {r_led[NUM_LED-2:0], r_led[NUM_LED-1]};
            end else begin
                w_led_nxt = ~r_led;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rate <= '0;
            r_led  <= '0;
            r_tick <= 1'b0;
        end else begin
            if (w_up_ok) begin
                r_rate <= r_rate + RATE_W'(1);
            end else if (w_dn_ok) begin
                r_rate <= r_rate - RATE_W'(1);
            end
            r_led  <= w_led_nxt;
            r_tick <= w_expire;
        end
    end

    assign bus.LED      = r_led;
    assign bus.RATE_IDX = r_rate;
    assign bus.MODE     = r_mode;
    assign bus.TICK     = r_tick;

endmodule
